// File: rtl/rv32i_pkg.sv
// Shared RV32I memory-access definitions: load/store width codes and data-port geometry.
package rv32i_pkg;

  localparam int NUM_BYTES = 16;

  typedef enum logic [2:0] {
    W_BYTE  = 3'b000,
    W_BYTEU = 3'b001,
    W_HALF  = 3'b010,
    W_HALFU = 3'b011,
    W_WORD  = 3'b100,
    W_WORDU = 3'b101,
    W_DBL   = 3'b110,
    W_RSVD  = 3'b111
  } width_t;

  // Lane-0-aligned masks; the downstream aligner applies the address offset.
  localparam logic [15:0] MASK_BYTE = 16'h0001;
  localparam logic [15:0] MASK_HALF = 16'h0003;
  localparam logic [15:0] MASK_WORD = 16'h000F;
  localparam logic [15:0] MASK_DBL  = 16'h00FF;

endpackage

// File: rtl/byte_mask_decode.sv
// Combinational decode of an RV32I width code into a lane-0-aligned byte-enable mask.
module byte_mask_decode
  import rv32i_pkg::*;
#(
  parameter int NUM_BYTES = rv32i_pkg::NUM_BYTES
) (
  input  logic [2:0]           width_type,
  input  logic                 enabler,
  output logic [NUM_BYTES-1:0] mask
);

  // The signedness bit does not affect which lanes are touched, so paired codes share a mask.
  always_comb begin
    mask = '0;
    if (enabler) begin
      case (width_t'(width_type))
        W_BYTE, W_BYTEU: mask = NUM_BYTES'(MASK_BYTE);
        W_HALF, W_HALFU: mask = NUM_BYTES'(MASK_HALF);
        W_WORD, W_WORDU: mask = NUM_BYTES'(MASK_WORD);
        W_DBL,  W_RSVD:  mask = NUM_BYTES'(MASK_DBL);
        default:         mask = '0;
      endcase
    end
  end

endmodule

// File: rtl/output_byte_handler_rv32i.sv
// Registered byte-enable generator for the 128-bit data port: one cycle of latency, synchronous clear.
module output_byte_handler_rv32i
  import rv32i_pkg::*;
#(
  parameter int NUM_BYTES = rv32i_pkg::NUM_BYTES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2:0]           width_type,
  input  logic                 enabler,
  output logic [NUM_BYTES-1:0] byte_enablers
);

  logic [NUM_BYTES-1:0] next_mask;

  byte_mask_decode #(
    .NUM_BYTES (NUM_BYTES)
  ) u_decode (
    .width_type (width_type),
    .enabler    (enabler),
    .mask       (next_mask)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_enablers <= '0;
    end else begin
      byte_enablers <= next_mask;
    end
  end

endmodule

// File: tb/tb_output_byte_handler_rv32i.sv
// Self-checking bench: directed width/enable/reset steps followed by randomized steps against an arithmetic model.
module tb_output_byte_handler_rv32i;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  width_type;
  logic        enabler;
  logic [15:0] byte_enablers;

  int checks   = 0;
  int failures = 0;

  logic [15:0] prev_exp  = 16'h0000;
  bit          have_prev = 1'b0;

  output_byte_handler_rv32i dut (
    .clk           (clk),
    .rst           (rst),
    .width_type    (width_type),
    .enabler       (enabler),
    .byte_enablers (byte_enablers)
  );

  always #5 clk = ~clk;

  // Lane count is 2^size; mask is that many low bits set.
  function automatic logic [15:0] model(input logic [2:0] wt, input logic en);
    int lanes;
    if (!en) return 16'h0000;
    lanes = 1 << int'(wt[2:1]);
    return 16'((1 << lanes) - 1);
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] expected);
    checks++;
    assert (byte_enablers === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, byte_enablers, expected);
    end
  endtask

  // Drive between edges, confirm the output still holds the old mask, then check after the edge.
  task automatic applyStimulus(input logic r, input logic [2:0] wt, input logic en, input string tag);
    logic [15:0] exp_v;
    @(negedge clk);
    rst        = r;
    width_type = wt;
    enabler    = en;
    #1;
    if (have_prev) checkOutput({tag, "_hold"}, prev_exp);
    @(posedge clk);
    #1;
    exp_v = r ? 16'h0000 : model(wt, en);
    checkOutput(tag, exp_v);
    prev_exp  = exp_v;
    have_prev = 1'b1;
  endtask

  initial begin
    logic       r_rand;
    logic [2:0] wt_rand;
    logic       en_rand;

    rst        = 1'b1;
    width_type = 3'b100;
    enabler    = 1'b1;

    applyStimulus(1'b1, 3'b100, 1'b1, "reset0");
    applyStimulus(1'b1, 3'b100, 1'b1, "reset1");
    applyStimulus(1'b0, 3'b100, 1'b1, "first_after_reset");

    applyStimulus(1'b0, 3'b000, 1'b1, "byte");
    applyStimulus(1'b0, 3'b001, 1'b1, "byteu");
    applyStimulus(1'b0, 3'b010, 1'b1, "half");
    applyStimulus(1'b0, 3'b011, 1'b1, "halfu");
    applyStimulus(1'b0, 3'b100, 1'b1, "word");
    applyStimulus(1'b0, 3'b101, 1'b1, "wordu");
    applyStimulus(1'b0, 3'b110, 1'b1, "dbl");
    applyStimulus(1'b0, 3'b111, 1'b1, "rsvd");

    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 3'(i), 1'b0, $sformatf("disable_%0d", i));
    end
    applyStimulus(1'b0, 3'b010, 1'b1, "reenable_half");

    applyStimulus(1'b0, 3'b000, 1'b1, "latency_byte");
    applyStimulus(1'b0, 3'b100, 1'b1, "latency_word");
    applyStimulus(1'b1, 3'b100, 1'b1, "midop_reset");
    applyStimulus(1'b0, 3'b010, 1'b1, "after_midop_reset");

    for (int i = 0; i < 200; i++) begin
      r_rand  = ($urandom_range(15) == 0);
      wt_rand = 3'($urandom_range(7));
      en_rand = 1'($urandom_range(1));
      applyStimulus(r_rand, wt_rand, en_rand, $sformatf("rand_%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
